drum_step_scheduler: RTL and testbench
======================================

# drum_step_scheduler

Step-timing and input-scheduling controller for the 16-step drum sequencer. It generates the one-cycle step enable (CCEN) from a tempo divisor adjustable at run time, and selects loop length (16/8/4 steps). It also captures asynchronous-in-time pad, Start and Stop pulses between steps, and delivers each one to the sequencer for exactly the CCEN cycle of the next step. It sits between the debounced button/pad front end and the sequencer state machine.

## Interface
- DIV_W, 27, width of tempo divisor and interval counter
- DIV_INIT, 12_500_000, divisor after reset (16th notes at 120 BPM, 100 MHz)
- DIV_MIN, 6_250_000, fastest allowed divisor
- DIV_MAX, 25_000_000, slowest allowed divisor
- DIV_STEP, 625_000, divisor change per tempo pulse
- Clk  in  1  system clock
- Reset  in  1  Reset, asynchronous, active-high; clock Clk
- TempoUp  in  1  single-cycle pulse, faster tempo
- TempoDown  in  1  single-cycle pulse, slower tempo
- LenSel  in  1  single-cycle pulse, cycle loop length
- StartReq  in  1  single-cycle pulse, request play
- StopReq  in  1  single-cycle pulse, request stop
- PadIn  in  5  single-cycle pad pulses, bit0=A … bit4=E
- Playing  in  1  sequencer is in a PLAY state
- CCEN  out  1  step enable, one cycle per interval
- Start  out  1  start strobe, coincident with CCEN
- Stop  out  1  stop strobe, coincident with CCEN
- Pads  out  5  pad toggles for this step, non-zero only with CCEN
- Fourths  out  1  4-step loop selected
- Eighths  out  1  8-step loop selected
- Divisor  out  DIV_W  current divisor

## Operation
- Interval counter: counts 0 upward each cycle. When count ≥ Divisor−1, it reloads 0 and the registered CCEN goes high for the next cycle. The period is exactly Divisor cycles.
- Tempo: TempoUp sets Divisor to max(Divisor−DIV_STEP, DIV_MIN). TempoDown sets Divisor to min(Divisor+DIV_STEP, DIV_MAX). Both in the same cycle: no change. The change applies immediately. The ≥ compare guarantees a shortened divisor fires on the next cycle rather than wrapping.
- Length FSM, states L16→L8→L4→L16 on each LenSel pulse:
  - L16: Fourths=0, Eighths=0.
  - L8: Eighths=1.
  - L4: Fourths=1.
- Pad capture: pend_next = CCEN_next ? PadIn : (pend | PadIn). Pads = pend while CCEN is high, else 0. A pulse arriving in the same cycle the counter wraps goes to the following step. Multiple pulses of one pad within one interval collapse to a single toggle.
- Start/Stop capture uses the same sticky-pending rule as pads.
  - If StopReq and StartReq are both pending at delivery, Stop=1 and Start=0, and both are cleared.
  - StartReq while Playing=1 is discarded.
  - StopReq while Playing=0 is discarded.

## Timing
- Reset values: CCEN=0, Start=0, Stop=0, Pads=0, Fourths=0, Eighths=0, Divisor=DIV_INIT, counter=0, all pending bits=0, length state L16.
- First CCEN is high in the cycle after DIV_INIT rising edges following Reset release.
- Tempo and LenSel: outputs update one cycle after the input pulse.
- Start/Stop/Pads are registered and aligned with CCEN, one cycle wide.
- Reset mid-interval clears the counter and all pending requests. No strobe is emitted.
- Counter width must hold DIV_MAX−1. Adding DIV_STEP must not overflow DIV_W.

## Configuration
- DRUM_SWING_EN defined:
  - Adds input port SwingOn (1 bit) and an internal step-parity bit. Parity toggles on each CCEN while Playing=1 and is held at 0 while Playing=0.
  - With SwingOn=1, the interval after an even step is Divisor + Divisor/4 and the interval after an odd step is Divisor − Divisor/4. Divisor/4 is a right shift by 2, truncating.
- DRUM_SWING_EN not defined: no SwingOn port, no parity bit. All intervals equal Divisor.

## Test plan
- Uniform period (bench params DIV_INIT=8, MIN=4, MAX=12, STEP=2): release Reset → CCEN high at cycles 8, 16, 24; Pads/Start/Stop stay 0.
- Tempo saturation: 3×TempoUp → Divisor 6, 4, 4. Then 5×TempoDown → 6, 8, 10, 12, 12. Simultaneous Up+Down → unchanged.
- Divisor shrink mid-interval: at count=6 with Divisor=8, pulse TempoUp twice → Divisor=4, and CCEN fires on the next cycle without waiting for a wrap.
- Pad capture: PadIn=5'b00001 twice and 5'b10000 once within one interval → Pads=5'b10001 for the CCEN cycle only. A pulse in the wrap cycle appears at the following CCEN.
- Start/Stop: with Playing=0, StartReq → Start=1 at the next CCEN. With Playing=1, StartReq+StopReq together → Stop=1, Start=0. StopReq with Playing=0 → no Stop.
- Length and swing: 3×LenSel → (Eighths,Fourths) = 10, 01, 00. With DRUM_SWING_EN, SwingOn=1, Divisor=8, Playing=1 → alternating intervals 10, 6.

Source files
------------

// File: rtl/drum_step_scheduler_if.sv
// drum_step_scheduler_if: scheduler bus between the pad/button front end, sequencer and step scheduler.
// SwingOn exists only when DRUM_SWING_EN is defined.
interface drum_step_scheduler_if #(parameter int DIV_W = 27);
    logic             TempoUp;
    logic             TempoDown;
    logic             LenSel;
    logic             StartReq;
    logic             StopReq;
    logic [4:0]       PadIn;
    logic             Playing;
    logic             CCEN;
    logic             Start;
    logic             Stop;
    logic [4:0]       Pads;
    logic             Fourths;
    logic             Eighths;
    logic [DIV_W-1:0] Divisor;
`ifdef DRUM_SWING_EN
    logic             SwingOn;
    modport master (output TempoUp, TempoDown, LenSel, StartReq, StopReq, PadIn, Playing, SwingOn,
                    input CCEN, Start, Stop, Pads, Fourths, Eighths, Divisor);
    modport slave (input TempoUp, TempoDown, LenSel, StartReq, StopReq, PadIn, Playing, SwingOn,
                   output CCEN, Start, Stop, Pads, Fourths, Eighths, Divisor);
`else
    modport master (output TempoUp, TempoDown, LenSel, StartReq, StopReq, PadIn, Playing,
                    input CCEN, Start, Stop, Pads, Fourths, Eighths, Divisor);
    modport slave (input TempoUp, TempoDown, LenSel, StartReq, StopReq, PadIn, Playing,
                   output CCEN, Start, Stop, Pads, Fourths, Eighths, Divisor);
`endif
endinterface

// File: rtl/drum_step_scheduler.sv
// drum_step_scheduler: step enable generation, tempo/loop-length control and per-step request scheduling.
// Optional swing timing is enabled with DRUM_SWING_EN.
module drum_step_scheduler #(
    parameter int DIV_W    = 27,
    parameter int DIV_INIT = 12_500_000,
    parameter int DIV_MIN  = 6_250_000,
    parameter int DIV_MAX  = 25_000_000,
    parameter int DIV_STEP = 625_000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    drum_step_scheduler_if.slave io_bus
);
    typedef enum logic [1:0] {L16, L8, L4} len_t;
    len_t             r_len, w_len_next;
    logic [DIV_W-1:0] r_cnt, r_div, w_limit, w_div_next;
    logic             r_ccen, r_start, r_stop, r_start_p, r_stop_p, w_wrap, w_up, w_down;
    logic [4:0]       r_pend, r_pads;
`ifdef DRUM_SWING_EN
    logic             r_par;
    // Even steps get the long interval, odd steps the short one.
    assign w_limit = !io_bus.SwingOn ? r_div : r_par ? r_div - (r_div >> 2) : r_div + (r_div >> 2);
`else
    assign w_limit = r_div;
`endif
    // >= lets a divisor shrunk below the running count fire at once instead of wrapping.
    assign w_wrap = r_cnt >= w_limit - DIV_W'(1);
    assign w_up   = io_bus.TempoUp & ~io_bus.TempoDown;
    assign w_down = io_bus.TempoDown & ~io_bus.TempoUp;
    assign w_div_next = w_up ? (r_div < DIV_W'(DIV_MIN + DIV_STEP) ? DIV_W'(DIV_MIN) : r_div - DIV_W'(DIV_STEP))
                      : w_down ? (r_div > DIV_W'(DIV_MAX - DIV_STEP) ? DIV_W'(DIV_MAX) : r_div + DIV_W'(DIV_STEP))
                      : r_div;
    always_comb begin
        w_len_next = r_len;
        if (io_bus.LenSel)
            w_len_next = r_len == L16 ? L8 : r_len == L8 ? L4 : L16;
    end
    always_ff @(posedge Clk or posedge Reset)
        if (Reset)
            r_len <= L16;
        else
            r_len <= w_len_next;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_div     <= DIV_W'(DIV_INIT);
            r_ccen    <= 1'b0;
            r_pads    <= '0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_pend    <= '0;
            r_start_p <= 1'b0;
            r_stop_p  <= 1'b0;
        end else begin
            r_cnt     <= w_wrap ? '0 : r_cnt + DIV_W'(1);
            r_div     <= w_div_next;
            r_ccen    <= w_wrap;
            r_pads    <= w_wrap ? r_pend : '0;
            r_stop    <= w_wrap & r_stop_p;
            r_start   <= w_wrap & r_start_p & ~r_stop_p;
            // Requests seen in the wrap cycle belong to the following step.
            r_pend    <= (w_wrap ? '0 : r_pend) | io_bus.PadIn;
            r_start_p <= (w_wrap ? 1'b0 : r_start_p) | (io_bus.StartReq & ~io_bus.Playing);
            r_stop_p  <= (w_wrap ? 1'b0 : r_stop_p) | (io_bus.StopReq & io_bus.Playing);
        end
    end
`ifdef DRUM_SWING_EN
    always_ff @(posedge Clk or posedge Reset)
        if (Reset)
            r_par <= 1'b0;
        else
            r_par <= io_bus.Playing & (r_par ^ r_ccen);
`endif
    assign io_bus.CCEN    = r_ccen;
    assign io_bus.Start   = r_start;
    assign io_bus.Stop    = r_stop;
    assign io_bus.Pads    = r_pads;
    assign io_bus.Fourths = r_len == L4;
    assign io_bus.Eighths = r_len == L8;
    assign io_bus.Divisor = r_div;
endmodule

// File: tb/tb_drum_step_scheduler.sv
// tb_drum_step_scheduler: randomized and directed checks of drum_step_scheduler against a cycle-level reference model.
// Define DRUM_SWING_EN to also exercise swing timing.
module tb_drum_step_scheduler;
    localparam int W = 8, DI = 8, DMIN = 4, DMAX = 12, DST = 2;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int n_checks = 0;
    int n_errors = 0;

    drum_step_scheduler_if #(.DIV_W(W)) bus ();
    drum_step_scheduler #(.DIV_W(W), .DIV_INIT(DI), .DIV_MIN(DMIN), .DIV_MAX(DMAX), .DIV_STEP(DST))
        dut (.Clk(Clk), .Reset(Reset), .io_bus(bus.slave));

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: elapsed cycles in the current step, tempo as saturating integer, pending request sets.
    int         m_div, m_since, m_len, m_span;
    bit         m_fire, m_sp, m_tp, m_ccen, m_start, m_stop;
    logic [4:0] m_pend, m_pads;
`ifdef DRUM_SWING_EN
    bit         m_par;
`endif
    always_comb begin
        m_span = m_div;
`ifdef DRUM_SWING_EN
        if (bus.SwingOn) m_span = m_par ? m_div - m_div / 4 : m_div + m_div / 4;
`endif
        m_fire = (m_since + 1 >= m_span);
    end
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_div <= DI; m_since <= 0; m_len <= 0; m_sp <= 0; m_tp <= 0;
            m_ccen <= 0; m_start <= 0; m_stop <= 0; m_pend <= 0; m_pads <= 0;
`ifdef DRUM_SWING_EN
            m_par <= 0;
`endif
        end else begin
            m_ccen  <= m_fire;
            m_pads  <= m_fire ? m_pend : 5'd0;
            m_stop  <= m_fire && m_tp;
            m_start <= m_fire && m_sp && !m_tp;
            m_pend  <= m_fire ? bus.PadIn : (m_pend | bus.PadIn);
            m_sp    <= (m_fire ? 1'b0 : m_sp) || (bus.StartReq && !bus.Playing);
            m_tp    <= (m_fire ? 1'b0 : m_tp) || (bus.StopReq && bus.Playing);
            m_since <= m_fire ? 0 : m_since + 1;
            if (bus.TempoUp && !bus.TempoDown) m_div <= (m_div - DST < DMIN) ? DMIN : m_div - DST;
            if (bus.TempoDown && !bus.TempoUp) m_div <= (m_div + DST > DMAX) ? DMAX : m_div + DST;
            if (bus.LenSel) m_len <= (m_len + 1) % 3;
`ifdef DRUM_SWING_EN
            m_par <= !bus.Playing ? 1'b0 : m_ccen ? !m_par : m_par;
`endif
        end
    end

    always @(negedge Clk)
        if (!Reset) begin
            check("m_ccen", bus.CCEN, m_ccen);
            check("m_start", bus.Start, m_start);
            check("m_stop", bus.Stop, m_stop);
            check("m_pads", bus.Pads, m_pads);
            check("m_div", bus.Divisor, m_div);
            check("m_eighths", bus.Eighths, m_len == 1);
            check("m_fourths", bus.Fourths, m_len == 2);
        end

    task automatic tick();
        @(negedge Clk);
        bus.TempoUp = 0; bus.TempoDown = 0; bus.LenSel = 0;
        bus.StartReq = 0; bus.StopReq = 0; bus.PadIn = 0;
    endtask

    task automatic wait_ccen();
        int k = 0;
        do begin tick(); k++; end while (!bus.CCEN && k < 64);
        if (!bus.CCEN) check("ccen_seen", bus.CCEN, 1);
    endtask

    int up_exp[3]   = '{6, 4, 4};
    int down_exp[5] = '{6, 8, 10, 12, 12};
    logic [1:0] len_exp[3] = '{2'b10, 2'b01, 2'b00};

    initial begin
        bus.TempoUp = 0; bus.TempoDown = 0; bus.LenSel = 0; bus.StartReq = 0;
        bus.StopReq = 0; bus.PadIn = 0; bus.Playing = 0;
`ifdef DRUM_SWING_EN
        bus.SwingOn = 0;
`endif
        repeat (3) @(negedge Clk);
        check("rst_ccen", bus.CCEN, 0);
        check("rst_div", bus.Divisor, DI);
        check("rst_len", {bus.Eighths, bus.Fourths}, 0);
        check("rst_strobes", {bus.Start, bus.Stop, bus.Pads}, 0);
        Reset = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            check("ccen_uniform", bus.CCEN, (c % 8) == 0);
        end
        foreach (up_exp[i]) begin
            bus.TempoUp = 1; tick();
            check("tempo_up", bus.Divisor, up_exp[i]);
        end
        foreach (down_exp[i]) begin
            bus.TempoDown = 1; tick();
            check("tempo_down", bus.Divisor, down_exp[i]);
        end
        bus.TempoUp = 1; bus.TempoDown = 1; tick();
        check("tempo_both", bus.Divisor, 12);
        bus.TempoUp = 1; tick();
        bus.TempoUp = 1; tick();
        check("tempo_back", bus.Divisor, 8);
        wait_ccen();
        repeat (6) tick();
        bus.TempoUp = 1; tick();
        check("shrink_wait", bus.CCEN, 0);
        bus.TempoUp = 1; tick();
        check("shrink_div", bus.Divisor, 4);
        check("shrink_fire", bus.CCEN, 1);
        bus.PadIn = 5'b00001; tick();
        bus.PadIn = 5'b00001; tick();
        bus.PadIn = 5'b10000; tick();
        bus.PadIn = 5'b00100; tick();
        check("pads_ccen", bus.CCEN, 1);
        check("pads_merge", bus.Pads, 5'b10001);
        tick();
        check("pads_one_cycle", bus.Pads, 0);
        wait_ccen();
        check("pads_wrap", bus.Pads, 5'b00100);
        bus.StartReq = 1; wait_ccen();
        check("start_idle", {bus.Start, bus.Stop}, 2'b10);
        bus.Playing = 1; bus.StartReq = 1; bus.StopReq = 1; wait_ccen();
        check("startstop_play", {bus.Start, bus.Stop}, 2'b01);
        bus.Playing = 0; bus.StartReq = 1; tick();
        bus.Playing = 1; bus.StopReq = 1; wait_ccen();
        check("stop_priority", {bus.Start, bus.Stop}, 2'b01);
        bus.Playing = 0; bus.StopReq = 1; wait_ccen();
        check("stop_idle", {bus.Start, bus.Stop}, 2'b00);
        foreach (len_exp[i]) begin
            bus.LenSel = 1; tick();
            check("len_cycle", {bus.Eighths, bus.Fourths}, len_exp[i]);
        end
`ifdef DRUM_SWING_EN
        bus.TempoDown = 1; tick();
        bus.TempoDown = 1; tick();
        check("swing_div", bus.Divisor, 8);
        bus.Playing = 1; bus.SwingOn = 1;
        wait_ccen(); wait_ccen();
        begin
            int a = 0, b = 0;
            do begin tick(); a++; end while (!bus.CCEN && a < 64);
            do begin tick(); b++; end while (!bus.CCEN && b < 64);
            check("swing_sum", a + b, 16);
            check("swing_alt", (a == 10 && b == 6) || (a == 6 && b == 10), 1);
        end
        bus.SwingOn = 0;
`endif
        for (int i = 0; i < 3000; i++) begin
            bus.TempoUp   = ($urandom_range(0, 15) == 0);
            bus.TempoDown = ($urandom_range(0, 15) == 0);
            bus.LenSel    = ($urandom_range(0, 15) == 0);
            bus.StartReq  = ($urandom_range(0, 7) == 0);
            bus.StopReq   = ($urandom_range(0, 7) == 0);
            bus.PadIn     = 5'($urandom) & 5'($urandom) & 5'($urandom);
            if ($urandom_range(0, 31) == 0) bus.Playing = !bus.Playing;
`ifdef DRUM_SWING_EN
            if (i % 100 == 0) bus.SwingOn = 1'($urandom);
`endif
            if (i == 1500) Reset = 1;
            tick();
            Reset = 0;
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
